// File: rtl/next_pc_predictor.sv
// next_pc_predictor
//
// Produces the value the PC register loads on the next rising edge:
// sequential PC+4, a dynamically predicted branch target, a held PC on
// stall, or a redirect when the execute stage resolves a mispredicted
// control transfer. Prediction comes from a 2-bit-counter branch history
// table (BHT) and a tagged branch target buffer (BTB). Both are trained
// from execute-stage resolution.
//
// Ports
//   clk           clock; all state updates on the rising edge
//   rst           synchronous, active-high reset
//   PC            current PC from the PC register
//   stall         front-end stall; hold the PC
//   ex_valid      execute holds a resolved branch or jump this cycle
//   ex_jump       resolved op is JAL/JALR (always taken)
//   ex_taken      resolved conditional-branch outcome
//   ex_pc         PC of the resolved op
//   ex_target     resolved target address
//   ex_pred_next  next PC that was predicted for ex_pc
//   next_PC       PC value to load on the next edge
//   pred_taken    next_PC is a predicted-taken BTB target
//   flush         mispredict detected; squash younger instructions
//
// There is no handshake on this block. Every input is sampled every cycle,
// and ex_valid qualifies the ex_* group for that cycle only.
module next_pc_predictor #(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_jump,
  input  logic             ex_taken,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_target,
  input  logic [WIDTH-1:0] ex_pred_next,
  output logic [WIDTH-1:0] next_PC,
  output logic             pred_taken,
  output logic             flush
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = WIDTH - INDEX_BITS - 2;

  // Table storage
  logic [1:0]          bht        [ENTRIES];
  logic                btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [WIDTH-1:0]    btb_target [ENTRIES];
  logic                btb_jump   [ENTRIES];

  // Fetch-side lookup
  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0]   pc_tag;
  logic                  pc_hit;
  logic                  pc_predict;
  logic [WIDTH-1:0]      pc_seq;

  assign pc_idx     = PC[INDEX_BITS+1:2];
  assign pc_tag     = PC[WIDTH-1:INDEX_BITS+2];
  assign pc_hit     = btb_valid[pc_idx] && (btb_tag[pc_idx] == pc_tag);
  // A jump entry is always taken, whatever the counter says.
  assign pc_predict = pc_hit && (btb_jump[pc_idx] || bht[pc_idx][1]);
  // Wraps modulo 2^WIDTH.
  assign pc_seq     = PC + WIDTH'(4);

  // Execute-side resolution
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  actual_taken;
  logic [WIDTH-1:0]      actual_next;
  logic                  mispredict;
  logic [1:0]            ex_cnt;
  logic [1:0]            ex_cnt_next;

  assign ex_idx       = ex_pc[INDEX_BITS+1:2];
  assign ex_tag       = ex_pc[WIDTH-1:INDEX_BITS+2];
  assign actual_taken = ex_jump || ex_taken;
  assign actual_next  = actual_taken ? ex_target : (ex_pc + WIDTH'(4));
  assign mispredict   = ex_valid && (actual_next != ex_pred_next);
  assign ex_cnt       = bht[ex_idx];

  // The low two address bits never take part in indexing or tagging.
  logic unused_low_bits;
  assign unused_low_bits = ^{PC[1:0], ex_pc[1:0]};

  // Saturating 2-bit counter step for conditional branches.
  always_comb begin
    ex_cnt_next = ex_cnt;
    if (ex_taken) begin
      if (ex_cnt != 2'b11) ex_cnt_next = ex_cnt + 2'b01;
    end else begin
      if (ex_cnt != 2'b00) ex_cnt_next = ex_cnt - 2'b01;
    end
  end

  // Next-PC select. The order is reset, redirect, stall, predicted target,
  // sequential. A redirect beats a stall because the stalled instruction is
  // on the wrong path anyway.
  always_comb begin
    next_PC    = pc_seq;
    pred_taken = 1'b0;
    flush      = 1'b0;
    if (rst) begin
      next_PC = '0;
    end else if (mispredict) begin
      next_PC = actual_next;
      flush   = 1'b1;
    end else if (stall) begin
      next_PC = PC;
    end else if (pc_predict) begin
      next_PC    = btb_target[pc_idx];
      pred_taken = 1'b1;
    end
  end

  // BHT counters and BTB valid bits carry a reset value. Training happens on
  // any resolved op and does not depend on stall or mispredict. Prediction
  // reads the old contents in the same cycle; there is no bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i]       <= 2'b01;
        btb_valid[i] <= 1'b0;
      end
    end else if (ex_valid) begin
      if (!ex_jump) bht[ex_idx] <= ex_cnt_next;
      if (actual_taken) btb_valid[ex_idx] <= 1'b1;
    end
  end

  // BTB payload needs no reset because it is qualified by btb_valid.
  always_ff @(posedge clk) begin
    if (!rst && ex_valid && actual_taken) begin
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= ex_target;
      btb_jump[ex_idx]   <= ex_jump;
    end
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
module tb_next_pc_predictor;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC = '0;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_jump = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic [31:0] ex_pred_next = '0;
  logic [31:0] next_PC;
  logic        pred_taken;
  logic        flush;

  always #5 clk = ~clk;

  next_pc_predictor #(.WIDTH(32), .INDEX_BITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .PC           (PC),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_jump      (ex_jump),
    .ex_taken     (ex_taken),
    .ex_pc        (ex_pc),
    .ex_target    (ex_target),
    .ex_pred_next (ex_pred_next),
    .next_PC      (next_PC),
    .pred_taken   (pred_taken),
    .flush        (flush)
  );

  // One record per cycle: inputs and the hand-computed outputs.
  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        exv;
    logic        exj;
    logic        ext;
    logic [31:0] expc;
    logic [31:0] extgt;
    logic [31:0] expred;
    logic [31:0] e_next;
    logic        e_pred;
    logic        e_flush;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic vec_t mk(string name, logic r, logic s, logic [31:0] pc,
                              logic exv, logic exj, logic ext,
                              logic [31:0] expc, logic [31:0] extgt,
                              logic [31:0] expred, logic [31:0] e_next,
                              logic e_pred, logic e_flush);
    vec_t v;
    v.name = name; v.rst = r; v.stall = s; v.pc = pc;
    v.exv = exv; v.exj = exj; v.ext = ext;
    v.expc = expc; v.extgt = extgt; v.expred = expred;
    v.e_next = e_next; v.e_pred = e_pred; v.e_flush = e_flush;
    return v;
  endfunction

  // Scoreboard compare
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver: apply one vector after the edge, check at the falling edge,
  // then let the rising edge commit any training.
  task automatic run_vec(vec_t v);
    rst = v.rst; stall = v.stall; PC = v.pc;
    ex_valid = v.exv; ex_jump = v.exj; ex_taken = v.ext;
    ex_pc = v.expc; ex_target = v.extgt; ex_pred_next = v.expred;
    exp_q.push_back(v.e_next);
    @(negedge clk);
    check({v.name, ".next_PC"}, next_PC, exp_q.pop_front());
    check({v.name, ".pred_taken"}, {31'b0, pred_taken}, {31'b0, v.e_pred});
    check({v.name, ".flush"}, {31'b0, flush}, {31'b0, v.e_flush});
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                name          rst s  pc            v  j  t  ex_pc     target    pred_next  exp_next      p  f
    vecs.push_back(mk("rst0",        1, 0, 32'h100,      0, 0, 0, 0,        0,        0,         32'h0,        0, 0));
    // Resolution during reset: no flush and no training.
    vecs.push_back(mk("rst1",        1, 0, 32'h100,      1, 1, 0, 32'h300,  32'h400,  32'h304,   32'h0,        0, 0));
    vecs.push_back(mk("seq",         0, 0, 32'h100,      0, 0, 0, 0,        0,        0,         32'h104,      0, 0));
    vecs.push_back(mk("no_train_rst",0, 0, 32'h300,      0, 0, 0, 0,        0,        0,         32'h304,      0, 0));
    // First taken resolution: redirect; the same-index fetch sees old contents.
    vecs.push_back(mk("train1",      0, 0, 32'h200,      1, 0, 1, 32'h200,  32'h180,  32'h204,   32'h180,      0, 1));
    vecs.push_back(mk("pred1",       0, 0, 32'h200,      0, 0, 0, 0,        0,        0,         32'h180,      1, 0));
    vecs.push_back(mk("alias",       0, 0, 32'h240,      0, 0, 0, 0,        0,        0,         32'h244,      0, 0));
    vecs.push_back(mk("train2",      0, 0, 32'h100,      1, 0, 1, 32'h200,  32'h180,  32'h180,   32'h104,      0, 0));
    vecs.push_back(mk("train3",      0, 0, 32'h200,      1, 0, 1, 32'h200,  32'h180,  32'h180,   32'h180,      1, 0));
    vecs.push_back(mk("nt1",         0, 0, 32'h500,      1, 0, 0, 32'h200,  32'h180,  32'h180,   32'h204,      0, 1));
    vecs.push_back(mk("hyst_keep",   0, 0, 32'h200,      0, 0, 0, 0,        0,        0,         32'h180,      1, 0));
    vecs.push_back(mk("nt2",         0, 0, 32'h0,        1, 0, 0, 32'h200,  32'h180,  32'h180,   32'h204,      0, 1));
    vecs.push_back(mk("hyst_drop",   0, 0, 32'h200,      0, 0, 0, 0,        0,        0,         32'h204,      0, 0));
    // JAL at 0x300 shares index 0 with 0x200 and overwrites that entry.
    vecs.push_back(mk("jal",         0, 0, 32'h300,      1, 1, 0, 32'h300,  32'h400,  32'h304,   32'h400,      0, 1));
    vecs.push_back(mk("jal_pred",    0, 0, 32'h300,      0, 0, 0, 0,        0,        0,         32'h400,      1, 0));
    vecs.push_back(mk("evicted",     0, 0, 32'h200,      0, 0, 0, 0,        0,        0,         32'h204,      0, 0));
    vecs.push_back(mk("stall_hit",   0, 1, 32'h300,      0, 0, 0, 0,        0,        0,         32'h300,      0, 0));
    vecs.push_back(mk("stall",       0, 1, 32'h500,      0, 0, 0, 0,        0,        0,         32'h500,      0, 0));
    vecs.push_back(mk("stall_redir", 0, 1, 32'h500,      1, 0, 1, 32'h560,  32'h600,  32'h564,   32'h600,      0, 1));
    vecs.push_back(mk("wrap",        0, 0, 32'hFFFFFFFC, 0, 0, 0, 0,        0,        0,         32'h0,        0, 0));
    vecs.push_back(mk("stall_okres", 0, 1, 32'h700,      1, 1, 0, 32'h300,  32'h400,  32'h400,   32'h700,      0, 0));
    // Mid-run reset discards everything learned.
    vecs.push_back(mk("rst_mid",     1, 0, 32'h300,      0, 0, 0, 0,        0,        0,         32'h0,        0, 0));
    vecs.push_back(mk("forgot_jal",  0, 0, 32'h300,      0, 0, 0, 0,        0,        0,         32'h304,      0, 0));
    vecs.push_back(mk("forgot_br",   0, 0, 32'h560,      1, 0, 0, 32'h560,  32'h600,  32'h564,   32'h564,      0, 0));

    #1;
    foreach (vecs[i]) run_vec(vecs[i]);

    // Counter floor: two not-taken from 01 must stick at 00, so one taken
    // brings it only to 01 (no prediction) and a second to 10.
    run_vec(mk("h_rst",   1, 0, 32'h0,   0, 0, 0, 0,       0,       0,       32'h0,   0, 0));
    run_vec(mk("h_nt1",   0, 0, 32'h800, 1, 0, 0, 32'h800, 32'h900, 32'h804, 32'h804, 0, 0));
    run_vec(mk("h_nt2",   0, 0, 32'h800, 1, 0, 0, 32'h800, 32'h900, 32'h804, 32'h804, 0, 0));
    run_vec(mk("h_tk1",   0, 0, 32'h100, 1, 0, 1, 32'h800, 32'h900, 32'h804, 32'h900, 0, 1));
    run_vec(mk("h_weak",  0, 0, 32'h800, 0, 0, 0, 0,       0,       0,       32'h804, 0, 0));
    run_vec(mk("h_tk2",   0, 0, 32'h100, 1, 0, 1, 32'h800, 32'h900, 32'h804, 32'h900, 0, 1));
    run_vec(mk("h_strong",0, 0, 32'h800, 0, 0, 0, 0,       0,       0,       32'h900, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/next_pc_predictor.md
# next_pc_predictor

Generates `next_PC` for the PC register each cycle: sequential PC+4, a dynamic branch prediction, a hold on stall, or a redirect when execute resolves a mispredicted control transfer. It sits directly upstream of the PC register and takes the registered `PC` back as its input. It holds a 2-bit-counter branch history table (BHT) and a tagged branch target buffer (BTB), both trained from execute-stage resolution.

## Interface
- `WIDTH`, 32, address/PC width in bits
- `INDEX_BITS`, 4, log2 of BHT/BTB entries (16 entries)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `PC`  in  WIDTH  current PC from the PC register
- `stall`  in  1  front-end stall; hold PC
- `ex_valid`  in  1  execute holds a resolved branch/jump this cycle
- `ex_jump`  in  1  resolved op is JAL/JALR (always taken)
- `ex_taken`  in  1  resolved conditional branch outcome
- `ex_pc`  in  WIDTH  PC of the resolved op
- `ex_target`  in  WIDTH  resolved target address
- `ex_pred_next`  in  WIDTH  next PC that was predicted for `ex_pc`, carried down the pipe
- `next_PC`  out  WIDTH  PC value to load next edge
- `pred_taken`  out  1  current `next_PC` is a predicted-taken target
- `flush`  out  1  mispredict detected; younger instructions must be squashed

## Operation
- Fields: index = `PC[INDEX_BITS+1:2]`; tag = `PC[WIDTH-1:INDEX_BITS+2]`. The same split applies to `ex_pc`.
- State per entry:
  - BHT counter, 2 bits.
  - BTB valid, tag, target (WIDTH bits) and jump bit.
- Prediction (combinational):
  - hit = valid & tag match.
  - Predict taken when hit & (jump bit | counter[1]).
  - seq = `PC`+4, modulo 2^WIDTH. 0xFFFFFFFC wraps to 0x00000000.
- Resolution:
  - actual_taken = `ex_jump` | `ex_taken`.
  - actual = actual_taken ? `ex_target` : `ex_pc`+4.
  - mispredict = `ex_valid` & (actual != `ex_pred_next`).
- `next_PC` selection, highest priority first:
  1. `rst` → 0.
  2. mispredict → actual.
  3. `stall` → `PC`.
  4. predict taken → BTB target.
  5. otherwise → seq.
- `pred_taken` = 1 only when selection 4 applies, else 0.
- `flush` = mispredict, with `rst` forcing 0.
- Training applies on any `ex_valid` cycle, independent of `stall` and mispredict:
  - BHT[ex index]: a conditional branch (`ex_jump`=0) increments saturating at 11 when taken and decrements saturating at 00 when not taken. A jump leaves the counter unchanged.
  - BTB[ex index]: when actual_taken, write valid=1, tag, target=`ex_target` and jump=`ex_jump`, overwriting any existing entry. When not taken, the BTB is unchanged.
- Reset, on a rising edge with `rst`=1:
  - All BHT counters go to 01 (weakly not-taken).
  - All BTB valid bits clear; tag and target are don't-care.
  - Training is suppressed on that edge.
  - `rst` asserted mid-operation discards all learned state.

## Timing
- `next_PC`, `pred_taken` and `flush` are combinational from `PC`, the tables and the `ex_*`/`stall` inputs. Zero-cycle latency, so the PC register captures the value at the same edge.
- Table writes land on the rising edge and are visible to prediction from the next cycle.
- Read and write of the same index in one cycle: prediction uses the old contents, with no bypass.
- Redirect latency: the mispredict is resolved in cycle N, and the PC register holds the corrected address after the N edge.
- Outputs while `rst`=1: `next_PC`=0, `pred_taken`=0, `flush`=0.
- Simultaneous `stall` and mispredict: the redirect wins and `flush`=1.
- Simultaneous BHT update and BTB allocate for the same entry: both are applied on the same edge.

## Test plan
- Reset: hold `rst` for 2 cycles with `PC`=0x100 → `next_PC`=0, `flush`=0. After release, `PC`=0x100 gives `next_PC`=0x104 and `pred_taken`=0.
- Train branch:
  - Resolve `ex_pc`=0x200, taken, target 0x180, `ex_pred_next`=0x204 → `flush`=1 and `next_PC`=0x180 that cycle.
  - Next cycle, `PC`=0x200 gives `next_PC`=0x180 and `pred_taken`=1 (counter is now 10).
- Saturation/hysteresis: train 0x200 taken three times, then not-taken once → still predicts 0x180. After a second not-taken → predicts 0x204.
- Jump: resolve JAL at 0x300 to 0x400 → `flush`=1. After that, `PC`=0x300 gives `next_PC`=0x400 regardless of the counter value.
- Stall vs redirect:
  - `stall`=1 with `PC`=0x500 → `next_PC`=0x500.
  - Same cycle plus a mispredict resolving to 0x600 → `next_PC`=0x600 and `flush`=1.
- Wrap and alias:
  - `PC`=0xFFFFFFFC gives `next_PC`=0x00000000.
  - An entry trained at 0x200 is not a hit for `PC`=0x240 (same index, different tag) → `next_PC`=0x244.
